instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, reads the instruction memory at that PC, produces PC+4 for the PC selection mux, and loads the IF/ID pipeline register. Consumes the next-PC value chosen by the PC mux; honours hazard-unit stalls, branch/jump flushes, the debug-unit run/step enable and the HALT instruction.

## Interface
- DATA_WIDTH, 32, datapath and instruction width
- IMEM_DEPTH, 256, instruction memory depth in words (power of two)
- ADDR_WIDTH, log2(IMEM_DEPTH) = 8, word-address width
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that halts fetch

Ports:
- i_clock  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset; highest priority
- i_enable  in  1  debug-unit run/step enable; 0 freezes PC, IF/ID and state
- i_stall  in  1  hazard-unit stall; holds PC and IF/ID
- i_flush  in  1  branch/jump taken; squashes IF/ID, forces PC update
- i_pc_next  in  DATA_WIDTH  next PC from the PC mux
- i_imem_wr_en  in  1  instruction memory write strobe (debug loader)
- i_imem_wr_addr  in  ADDR_WIDTH  word address for write
- i_imem_wr_data  in  DATA_WIDTH  word to write
- o_pc  out  DATA_WIDTH  current PC register
- o_pc_incr  out  DATA_WIDTH  o_pc + 4, combinational, to the PC mux increment input
- o_ifid_instr  out  DATA_WIDTH  IF/ID instruction
- o_ifid_pc_incr  out  DATA_WIDTH  IF/ID PC+4
- o_ifid_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  fetch is in HALTED state

## Operation
- Fetch word: imem[o_pc[ADDR_WIDTH+1:2]], asynchronous read. If o_pc[DATA_WIDTH-1:ADDR_WIDTH+2] ≠ 0 or o_pc[1:0] ≠ 0, fetched word is 32'h0 (NOP).
- o_pc_incr = o_pc + 4, modulo 2^DATA_WIDTH (32'hFFFFFFFC -> 0).
- Memory write: on edge when i_imem_wr_en = 1, independent of i_enable, i_stall and state; not cleared by reset. Same-cycle write/fetch of one address: fetch sees old word.
- States: RUN, HALTED. Priority per edge: reset > !i_enable (hold all) > flush > stall > normal.
- Flush (i_enable=1, i_flush=1, any state, stall ignored): PC <= i_pc_next; IF/ID <= {0, 0, valid 0}; state <= RUN. A HALT_WORD fetched in the same cycle is discarded.
- Stall (i_enable=1, i_flush=0, i_stall=1): PC, IF/ID, state hold.
- RUN advance (enable, no flush, no stall):
  - fetched ≠ HALT_WORD: PC <= i_pc_next; IF/ID <= {fetched, o_pc_incr, 1}.
  - fetched = HALT_WORD: PC holds; IF/ID <= {HALT_WORD, o_pc_incr, 1}; state <= HALTED.
- HALTED advance: PC holds; IF/ID <= {0, 0, 0} (bubbles drain pipeline); stays HALTED until flush or reset.
- o_halted = (state == HALTED).

## Timing
- Reset values: o_pc 0, o_ifid_instr 0, o_ifid_pc_incr 0, o_ifid_valid 0, o_halted 0, state RUN; o_pc_incr = 4.
- Fetch-to-IF/ID latency: 1 cycle; instruction at PC visible on o_ifid_instr the cycle after the advancing edge.
- o_halted asserts the cycle after the HALT word is latched into IF/ID (same edge).
- o_pc_incr follows o_pc combinationally, same cycle.
- Reset asserted mid-run: all registers return to reset values on that edge regardless of enable/stall/flush; imem contents retained.

## Test plan
- Load imem[0..2] = 32'h20010005, 32'h20020003, 32'hFFFFFFFF; reset; i_enable=1, i_pc_next = o_pc_incr -> o_ifid_instr 20010005, 20020003, FFFFFFFF on successive cycles; then o_halted=1, o_pc=8, o_ifid_valid=0 thereafter.
- At o_pc=4 assert i_stall 2 cycles -> o_pc stays 4, o_ifid_instr stays 20010005 both cycles; resumes 20020003 after release.
- At o_pc=4 assert i_stall and i_flush with i_pc_next=32'h40 -> next cycle o_pc=40, o_ifid_valid=0, o_ifid_instr=0.
- While HALTED, pulse i_flush with i_pc_next=0 -> o_halted=0, o_pc=0, next advance fetches 20010005; flush on cycle HALT is fetched -> no halt.
- i_enable=0 for 3 cycles while writing imem[1]=32'h12345678 -> o_pc/IF/ID/state frozen; after enable, PC=4 fetches 12345678.
- i_pc_next=32'h400 (out of range) -> o_ifid_instr=0, o_ifid_valid=1, o_ifid_pc_incr=404; reset mid-run -> all outputs at reset values next cycle, imem intact.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, asynchronous-read instruction memory,
// PC+4 generation and the IF/ID pipeline register, with stall/flush/halt control.
module instruction_fetch #(
   parameter int                      DATA_WIDTH = 32,
   parameter int                      IMEM_DEPTH = 256,
   parameter int                      ADDR_WIDTH = $clog2(IMEM_DEPTH),
   parameter logic [DATA_WIDTH-1:0]   HALT_WORD  = 32'hFFFFFFFF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_pc_next,
   input  logic                  i_imem_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_imem_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_imem_wr_data,
   output logic [DATA_WIDTH-1:0] o_pc,
   output logic [DATA_WIDTH-1:0] o_pc_incr,
   output logic [DATA_WIDTH-1:0] o_ifid_instr,
   output logic [DATA_WIDTH-1:0] o_ifid_pc_incr,
   output logic                  o_ifid_valid,
   output logic                  o_halted
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   pc_q, pc_d;
   logic [DATA_WIDTH-1:0]   ifid_instr_q, ifid_instr_d;
   logic [DATA_WIDTH-1:0]   ifid_pc_incr_q, ifid_pc_incr_d;
   logic                    ifid_valid_q, ifid_valid_d;

   logic [DATA_WIDTH-1:0]   imem_q [IMEM_DEPTH];
   logic [DATA_WIDTH-1:0]   fetch_word;
   logic [DATA_WIDTH-1:0]   pc_incr;
   logic                    pc_out_of_range;

   // Loader port: not reset and not gated, so program contents survive reset.
   always_ff @(posedge i_clock) begin
      if (i_imem_wr_en) begin
         imem_q[i_imem_wr_addr] <= i_imem_wr_data;
      end
   end

   // Addresses beyond the memory or not word-aligned fetch a NOP.
   assign pc_out_of_range = (|pc_q[DATA_WIDTH-1:ADDR_WIDTH+2]) || (|pc_q[1:0]);
   assign fetch_word      = pc_out_of_range ? '0 : imem_q[pc_q[ADDR_WIDTH+1:2]];
   assign pc_incr         = pc_q + DATA_WIDTH'(4);

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pc_incr_d = ifid_pc_incr_q;
      ifid_valid_d   = ifid_valid_q;

      if (!i_enable) begin
         state_d = state_q;
      end else if (i_flush) begin
         pc_d           = i_pc_next;
         ifid_instr_d   = '0;
         ifid_pc_incr_d = '0;
         ifid_valid_d   = 1'b0;
         state_d        = ST_RUN;
      end else if (i_stall) begin
         state_d = state_q;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               ifid_instr_d   = fetch_word;
               ifid_pc_incr_d = pc_incr;
               ifid_valid_d   = 1'b1;
               // HALT still enters IF/ID but the PC parks on it.
               if (fetch_word == HALT_WORD) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d = i_pc_next;
               end
            end
            ST_HALTED: begin
               ifid_instr_d   = '0;
               ifid_pc_incr_d = '0;
               ifid_valid_d   = 1'b0;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q        <= ST_RUN;
         pc_q           <= '0;
         ifid_instr_q   <= '0;
         ifid_pc_incr_q <= '0;
         ifid_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pc_incr_q <= ifid_pc_incr_d;
         ifid_valid_q   <= ifid_valid_d;
      end
   end

   assign o_pc           = pc_q;
   assign o_pc_incr      = pc_incr;
   assign o_ifid_instr   = ifid_instr_q;
   assign o_ifid_pc_incr = ifid_pc_incr_q;
   assign o_ifid_valid   = ifid_valid_q;
   assign o_halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: each step queues the expected post-edge
// state, clocks the DUT, then pops and checks every output.
module tb_instruction_fetch;

   logic        clk;
   logic        i_reset, i_enable, i_stall, i_flush;
   logic [31:0] i_pc_next;
   logic        i_imem_wr_en;
   logic [7:0]  i_imem_wr_addr;
   logic [31:0] i_imem_wr_data;
   logic [31:0] o_pc, o_pc_incr, o_ifid_instr, o_ifid_pc_incr;
   logic        o_ifid_valid, o_halted;

   logic        follow;
   logic [31:0] pc_drv;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        valid;
      logic        halted;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   instruction_fetch dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_enable       (i_enable),
      .i_stall        (i_stall),
      .i_flush        (i_flush),
      .i_pc_next      (i_pc_next),
      .i_imem_wr_en   (i_imem_wr_en),
      .i_imem_wr_addr (i_imem_wr_addr),
      .i_imem_wr_data (i_imem_wr_data),
      .o_pc           (o_pc),
      .o_pc_incr      (o_pc_incr),
      .o_ifid_instr   (o_ifid_instr),
      .o_ifid_pc_incr (o_ifid_pc_incr),
      .o_ifid_valid   (o_ifid_valid),
      .o_halted       (o_halted)
   );

   // PC mux stand-in: sequential fetch, or a directed target.
   assign i_pc_next = follow ? o_pc_incr : pc_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] ipc, input logic valid, input logic halted);
      exp_t e;
      exp_t g;
      e.tag = tag; e.pc = pc; e.instr = instr; e.ipc = ipc; e.valid = valid; e.halted = halted;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk({g.tag, ".pc"},        o_pc,                  g.pc);
      chk({g.tag, ".pc_incr"},   o_pc_incr,             g.pc + 32'd4);
      chk({g.tag, ".instr"},     o_ifid_instr,          g.instr);
      chk({g.tag, ".ifid_pc4"},  o_ifid_pc_incr,        g.ipc);
      chk({g.tag, ".valid"},     {31'd0, o_ifid_valid}, {31'd0, g.valid});
      chk({g.tag, ".halted"},    {31'd0, o_halted},     {31'd0, g.halted});
   endtask

   task automatic load(input logic [7:0] addr, input logic [31:0] data);
      i_imem_wr_en   = 1'b1;
      i_imem_wr_addr = addr;
      i_imem_wr_data = data;
      @(posedge clk);
      #1;
      i_imem_wr_en   = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      follow = 1'b0; pc_drv = 32'd0;
      i_imem_wr_en = 1'b0; i_imem_wr_addr = 8'd0; i_imem_wr_data = 32'd0;
      @(posedge clk);
      #1;
      load(8'd0,  32'h20010005);
      load(8'd1,  32'h20020003);
      load(8'd2,  32'hFFFFFFFF);
      load(8'd16, 32'hAAAA0001);
      step("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Sequential run with a two-cycle stall at PC=4, then HALT.
      i_reset = 1'b0; i_enable = 1'b1; follow = 1'b1;
      step("run0", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      i_stall = 1'b1;
      step("stall1", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      step("stall2", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      i_stall = 1'b0;
      step("run1", 32'h8, 32'h20020003, 32'h8, 1'b1, 1'b0);
      step("halt_fetch", 32'h8, 32'hFFFFFFFF, 32'hC, 1'b1, 1'b1);
      step("halted1", 32'h8, 32'h0, 32'h0, 1'b0, 1'b1);
      step("halted2", 32'h8, 32'h0, 32'h0, 1'b0, 1'b1);

      // Flush out of HALTED, refetch from 0.
      follow = 1'b0; pc_drv = 32'h0; i_flush = 1'b1;
      step("flush_halted", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      i_flush = 1'b0; follow = 1'b1;
      step("refetch", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);

      // Flush wins over stall.
      i_stall = 1'b1; i_flush = 1'b1; follow = 1'b0; pc_drv = 32'h40;
      step("stall_flush", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
      i_stall = 1'b0; pc_drv = 32'h0;
      step("flush_back", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Flush in the cycle the HALT word is fetched: no halt.
      i_flush = 1'b0; follow = 1'b1;
      step("adv_a", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      step("adv_b", 32'h8, 32'h20020003, 32'h8, 1'b1, 1'b0);
      i_flush = 1'b1; follow = 1'b0; pc_drv = 32'h0;
      step("flush_on_halt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      i_flush = 1'b0; follow = 1'b1;
      step("adv_c", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);

      // Disabled for three cycles while the loader rewrites imem[1].
      i_enable = 1'b0;
      i_imem_wr_en = 1'b1; i_imem_wr_addr = 8'd1; i_imem_wr_data = 32'h12345678;
      step("dis1", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      i_imem_wr_en = 1'b0; i_flush = 1'b1;
      step("dis2", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      i_flush = 1'b0; i_stall = 1'b1;
      step("dis3", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      i_stall = 1'b0; i_enable = 1'b1; follow = 1'b0; pc_drv = 32'h400;
      step("after_en", 32'h400, 32'h12345678, 32'h8, 1'b1, 1'b0);

      // Out-of-range and misaligned PCs fetch NOPs.
      follow = 1'b1;
      step("oor", 32'h404, 32'h0, 32'h404, 1'b1, 1'b0);
      follow = 1'b0; pc_drv = 32'h2;
      step("oor2", 32'h2, 32'h0, 32'h408, 1'b1, 1'b0);
      pc_drv = 32'h4;
      step("misalign", 32'h4, 32'h0, 32'h6, 1'b1, 1'b0);

      // Reset mid-run overrides disable/flush/stall; imem survives.
      i_reset = 1'b1; i_enable = 1'b0; i_flush = 1'b1; i_stall = 1'b1;
      step("reset_mid", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      i_reset = 1'b0; i_enable = 1'b1; i_flush = 1'b0; i_stall = 1'b0; follow = 1'b1;
      i_imem_wr_en = 1'b1; i_imem_wr_addr = 8'd0; i_imem_wr_data = 32'hDEADBEEF;
      step("post_rst0", 32'h4, 32'h20010005, 32'h4, 1'b1, 1'b0);
      i_imem_wr_en = 1'b0;
      step("post_rst1", 32'h8, 32'h12345678, 32'h8, 1'b1, 1'b0);

      // PC+4 wraps at the top of the address space.
      i_flush = 1'b1; follow = 1'b0; pc_drv = 32'hFFFFFFFC;
      step("wrap_set", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0);
      i_flush = 1'b0; follow = 1'b1;
      step("wrap_adv", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      step("new_word", 32'h4, 32'hDEADBEEF, 32'h4, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
